chan_mux: RTL and testbench

Parametrised, registered N-channel multiplexer with valid/ready handshakes on every input and on the output. It selects one input word per cycle, either from a fixed channel (`sel`) or by round-robin arbitration over all valid channels, and holds it in an output register until the consumer accepts it. It sits between several producer streams and a single shared consumer, replacing bare combinational select logic wherever back-pressure and fair sharing are needed.

---
 rtl/chan_mux.sv | 119 +++++++++++
 tb/tb_chan_mux.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/chan_mux.sv
// Registered N-channel multiplexer with valid/ready on every input and the output.
// Each word comes either from a fixed channel or from a round-robin search that starts at ptr_q.
module chan_mux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SELW     = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mode,
   input  logic [SELW-1:0]           sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_chan_q, out_chan_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   logic                grant_vld;
   logic [SELW-1:0]     grant_idx;
   logic [WIDTH-1:0]    grant_data;
   logic [CHANNELS-1:0] rot_valid;
   logic [SELW:0]       rr_sum;
   logic                load;
   logic                xfer;

   // Round-robin: rotate the valid vector so bit 0 is channel ptr_q.
   // The lowest set bit is then the first channel in search order.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      rot_valid = CHANNELS'({in_valid, in_valid} >> ptr_q);
      rr_sum    = '0;
      if (!mode) begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SELW'(k) && in_valid[k]) begin
               grant_vld = 1'b1;
               grant_idx = sel;
            end
         end
      end else begin
         for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rot_valid[i]) begin
               grant_vld = 1'b1;
               rr_sum    = {1'b0, ptr_q} + (SELW + 1)'(i);
            end
         end
         if (rr_sum >= (SELW + 1)'(CHANNELS)) begin
            rr_sum = rr_sum - (SELW + 1)'(CHANNELS);
         end
         grant_idx = rr_sum[SELW-1:0];
      end
   end

   always_comb begin
      grant_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (grant_idx == SELW'(k)) begin
            grant_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Output process: handshake decode
   always_comb begin
      load      = (state_q == EMPTY) || out_ready;
      xfer      = !rst && load && grant_vld;
      out_valid = (state_q == FULL);
      in_ready  = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (xfer && grant_idx == SELW'(k)) begin
            in_ready[k] = 1'b1;
         end
      end
   end

   // Next-state process: a drain with no new word empties the register
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_chan_d = out_chan_q;
      ptr_d      = ptr_q;
      if (xfer) begin
         state_d    = FULL;
         out_data_d = grant_data;
         out_chan_d = grant_idx;
         ptr_d      = (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + SELW'(1);
      end else if (state_q == FULL && out_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         out_data_q <= '0;
         out_chan_q <= '0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_chan_q <= out_chan_d;
         ptr_q      <= ptr_d;
      end
   end

   assign out_data = out_data_q;
   assign out_chan = out_chan_q;

endmodule

// File: tb/tb_chan_mux.sv
// Bench for chan_mux: directed steps followed by random traffic, all checked against a
// transaction-level model of the output register and round-robin pointer.
module tb_chan_mux;
   localparam int W  = 8;
   localparam int C  = 4;
   localparam int SW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, mode, out_ready;
   logic [SW-1:0]   sel;
   logic [C*W-1:0]  in_data;
   logic [C-1:0]    in_valid, in_ready;
   logic [W-1:0]    out_data;
   logic [SW-1:0]   out_chan;
   logic            out_valid;

   chan_mux #(.WIDTH(W), .CHANNELS(C), .SELW(SW)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   // Three-channel instance for the out-of-range select case
   logic         mode3, out_ready3, out_valid3;
   logic [1:0]   sel3, out_chan3;
   logic [23:0]  in_data3;
   logic [2:0]   in_valid3, in_ready3;
   logic [7:0]   out_data3;

   chan_mux #(.WIDTH(8), .CHANNELS(3), .SELW(2)) dut3 (
      .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
      .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
      .out_ready(out_ready3)
   );

   int n_checks = 0;
   int n_err    = 0;

   bit       m_full;
   bit [7:0] m_data;
   int       m_chan;
   int       m_ptr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Channel that should be granted right now, or -1 for none
   function automatic int model_grant();
      if (!mode) return (int'(sel) < C && in_valid[sel]) ? int'(sel) : -1;
      for (int i = 0; i < C; i++) begin
         if (in_valid[(m_ptr + i) % C]) return (m_ptr + i) % C;
      end
      return -1;
   endfunction

   task automatic cycle(output logic [C-1:0] xfer);
      int g;
      bit load;
      #2;
      g    = model_grant();
      load = !m_full || out_ready;
      xfer = '0;
      if (!rst && load && g >= 0) xfer[g] = 1'b1;
      chk("in_ready", in_ready, xfer);
      @(posedge clk);
      if (rst) begin
         m_full = 0; m_data = 0; m_chan = 0; m_ptr = 0;
      end else if (xfer != 0) begin
         m_full = 1;
         m_data = in_data[g*W +: W];
         m_chan = g;
         m_ptr  = (g + 1) % C;
      end else if (out_ready) begin
         m_full = 0;
      end
      #1;
      chk("out_valid", out_valid, m_full);
      chk("out_data", out_data, m_data);
      chk("out_chan", out_chan, m_chan);
   endtask

   initial begin
      logic [C-1:0] x;
      int rr_exp[5] = '{0, 1, 2, 3, 0};
      int sp_exp[4] = '{3, 1, 3, 1};

      rst = 1'b1; mode = 1'b0; sel = 2'd2; out_ready = 1'b1; in_valid = '1;
      in_data = {8'hC3, 8'hA5, 8'h3C, 8'h5A};
      mode3 = 1'b0; sel3 = 2'd3; in_valid3 = '1; in_data3 = {8'h77, 8'h66, 8'h55}; out_ready3 = 1'b1;
      m_full = 0; m_data = 0; m_chan = 0; m_ptr = 0;

      for (int i = 0; i < 2; i++) begin
         cycle(x);
         chk("rst_valid", out_valid, 1'b0);
         chk("rst_data", out_data, 8'h00);
      end

      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("fixed_rdy", in_ready, 4'b0100);
         cycle(x);
         chk("fixed_data", out_data, 8'hA5);
         chk("fixed_chan", out_chan, 2);
         chk("fixed_valid", out_valid, 1'b1);
      end

      // Serve channel 3 so round-robin starts at channel 0
      sel = 2'd3;
      cycle(x);
      chk("fixed3_chan", out_chan, 3);

      mode = 1'b1;
      in_data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int i = 0; i < 5; i++) begin
         cycle(x);
         chk("rr_chan", out_chan, rr_exp[i]);
         chk("rr_data", out_data, 8'h10 + rr_exp[i]);
         chk("rr_valid", out_valid, 1'b1);
      end

      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(x);
         chk("bp_data", out_data, 8'h10);
         chk("bp_rdy", in_ready, 4'b0000);
      end
      out_ready = 1'b1;
      cycle(x);
      chk("bp_resume_chan", out_chan, 1);
      chk("bp_resume_data", out_data, 8'h11);

      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         cycle(x);
         chk("sparse_chan", out_chan, sp_exp[i]);
      end

      rst = 1'b1;
      cycle(x);
      chk("rst_full_valid", out_valid, 1'b0);
      rst = 1'b0;

      in_valid = '0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         sel       = SW'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 63) == 0);
         for (int k = 0; k < C; k++) begin
            if (!in_valid[k] && $urandom_range(0, 1) == 1) begin
               in_valid[k]       = 1'b1;
               in_data[k*W +: W] = W'($urandom);
            end
         end
         cycle(x);
         in_valid = in_valid & ~x;
      end
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         #2;
         chk("c3_rdy", in_ready3, 3'b000);
         @(posedge clk);
         #1;
         chk("c3_valid", out_valid3, 1'b0);
      end
      sel3 = 2'd2;
      #2;
      chk("c3_sel2_rdy", in_ready3, 3'b100);
      @(posedge clk);
      #1;
      chk("c3_sel2_valid", out_valid3, 1'b1);
      chk("c3_sel2_data", out_data3, 8'h77);
      chk("c3_sel2_chan", out_chan3, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
